// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory read bus between the fetch stage and instruction memory.
//
// Signals:
//   mem_rd     fetch -> mem  read strobe, high for the whole outstanding read
//   mem_addr   fetch -> mem  16-bit read address (the current pc)
//   mem_rdata  mem -> fetch  16-bit read data, valid in the mem_ack cycle
//   mem_ack    mem -> fetch  read completion, only meaningful while mem_rd=1
//
// Modports:
//   master  used by the fetch stage
//   slave   used by the instruction memory (or a testbench model of it)
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch unit: owns the program counter and the instruction
// register. A fetch is requested from IDLE, the read is held open in WAIT
// until memory acknowledges, and DONE flags a freshly loaded instruction for
// one cycle. The control FSM can overwrite the pc at any time (jump / bne).
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   fetch_req      request a fetch (looked at only in IDLE)
//   pc_write       unconditional pc load from jump_target
//   pc_write_cond  pc load from jump_target when alu_zero==0
//   alu_zero       ALU zero flag qualifying pc_write_cond
//   jump_target    16-bit pc load value
//   mem            fetch_stage_if.master instruction-memory read bus
//   inst           instruction register
//   opcode         inst[3:0]
//   inst_valid     one-cycle pulse, inst holds a newly fetched instruction
//   busy           high whenever not IDLE
//   pc             program counter
//   fetch_err      sticky fetch-timeout flag
//
// Configuration:
//   FETCH_TIMEOUT_EN  when defined, a read that sees no mem_ack for 16
//                     consecutive WAIT cycles is abandoned and fetch_err is
//                     set. When undefined, WAIT lasts until mem_ack and
//                     fetch_err is tied to 0.
// ---------------------------------------------------------------------------
module fetch_stage (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_req,
  input  logic                 pc_write,
  input  logic                 pc_write_cond,
  input  logic                 alu_zero,
  input  logic [15:0]          jump_target,
  fetch_stage_if.master        mem,
  output logic [15:0]          inst,
  output logic [3:0]           opcode,
  output logic                 inst_valid,
  output logic                 busy,
  output logic [15:0]          pc,
  output logic                 fetch_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       ack_taken;
  logic       pc_load;
  logic       timeout;

  // mem_ack only counts while the read is actually outstanding
  assign ack_taken = (state == ST_WAIT) && mem.mem_ack;
  assign pc_load   = pc_write || (pc_write_cond && !alu_zero);

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] timeout_cnt;

  // Counter value 15 with no ack means this is the 16th silent WAIT cycle;
  // an ack in the same cycle still completes the fetch normally.
  assign timeout = (state == ST_WAIT) && !mem.mem_ack && (timeout_cnt == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_cnt <= 4'h0;
      fetch_err   <= 1'b0;
    end else begin
      if (state == ST_IDLE && fetch_req) begin
        timeout_cnt <= 4'h0;
      end else if (state == ST_WAIT && !mem.mem_ack) begin
        timeout_cnt <= timeout_cnt + 4'h1;
      end
      if (timeout) begin
        fetch_err <= 1'b1;
      end
    end
  end
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (fetch_req) state_next = ST_WAIT;
      ST_WAIT: begin
        if (mem.mem_ack) begin
          state_next = ST_DONE;
        end else if (timeout) begin
          state_next = ST_IDLE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // A control load outranks the fetch increment, but the IR still captures
  // the returning instruction in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= 16'h0000;
      inst  <= 16'h0000;
    end else begin
      state <= state_next;
      if (pc_load) begin
        pc <= jump_target;
      end else if (ack_taken) begin
        pc <= pc + 16'd2;
      end
      if (ack_taken) begin
        inst <= mem.mem_rdata;
      end
    end
  end

  assign mem.mem_rd   = (state == ST_WAIT);
  assign mem.mem_addr = pc;
  assign opcode       = inst[3:0];
  assign inst_valid   = (state == ST_DONE);
  assign busy         = (state != ST_IDLE);

endmodule
